// File: rtl/alu_operand_stage_pkg.sv
// Purpose : shared constants for the ALU operand-fetch stage (field positions, opcodes, ALU codes).
// Latency : n/a (declarations only).
// Backpressure: n/a.
package alu_operand_stage_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int REG_ADDR_WIDTH_DEF = 5;
  localparam int OPRN_WIDTH_DEF     = 6;

  // Instruction field LSB positions (MIPS-style encoding).
  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;

  // Major opcodes.
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0a;
  localparam logic [5:0] OPC_ANDI  = 6'h0c;
  localparam logic [5:0] OPC_ORI   = 6'h0d;
  localparam logic [5:0] OPC_LUI   = 6'h0f;
  localparam logic [5:0] OPC_MULI  = 6'h1d;

  // R-type function codes.
  localparam logic [5:0] FN_SLL = 6'h01;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_MUL = 6'h2c;

  // Operation codes understood by the downstream ALU.
  typedef enum logic [5:0] {
    ALU_NOP = 6'h00,
    ALU_ADD = 6'h01,
    ALU_SUB = 6'h02,
    ALU_MUL = 6'h03,
    ALU_SRL = 6'h04,
    ALU_SLL = 6'h05,
    ALU_AND = 6'h06,
    ALU_OR  = 6'h07,
    ALU_NOR = 6'h08,
    ALU_SLT = 6'h09
  } alu_oprn_e;

endpackage

// File: rtl/register_file_32x32.sv
// Purpose : 32-entry register file, 2 async read ports, 1 sync write port, R0 hardwired to zero.
// Latency : reads combinational; write visible the cycle after the write edge.
// Backpressure: none; writes always accepted.
// Ports: clk/rst (async active-high), rd0/rd1 addr->data, we/waddr/wdata write port.
module register_file_32x32 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rd0_addr,
  output logic [DATA_WIDTH-1:0] rd0_data,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic [DATA_WIDTH-1:0] rd1_data,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Entry 0 is never written, but force zero on read so it cannot be disturbed.
  assign rd0_data = (rd0_addr == '0) ? '0 : regs_q[rd0_addr];
  assign rd1_data = (rd1_addr == '0) ? '0 : regs_q[rd1_addr];

endmodule

// File: rtl/alu_operand_stage.sv
// Purpose : decode a MIPS-style instruction, fetch operands, drive registered OP1/OP2/OPRN/DEST to the ALU.
// Latency : 1 cycle from accept to OUT_VALID; full throughput back-to-back.
// Backpressure: IN_READY = !OUT_VALID || OUT_READY; outputs hold while OUT_VALID && !OUT_READY.
// Ports: CLK/RST (async active-high); INSTR/IN_VALID/IN_READY in; OP1/OP2/OPRN/DEST/ILLEGAL/OUT_VALID/OUT_READY out;
//        WB_EN/WB_ADDR/WB_DATA register write-back.
// Build option: OPERAND_BYPASS_EN forwards a same-cycle write-back into the captured operands.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int OPRN_WIDTH     = OPRN_WIDTH_DEF
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [31:0]               INSTR,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  output logic [DATA_WIDTH-1:0]     OP1,
  output logic [DATA_WIDTH-1:0]     OP2,
  output logic [OPRN_WIDTH-1:0]     OPRN,
  output logic [REG_ADDR_WIDTH-1:0] DEST,
  output logic                      ILLEGAL,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  input  logic                      WB_EN,
  input  logic [REG_ADDR_WIDTH-1:0] WB_ADDR,
  input  logic [DATA_WIDTH-1:0]     WB_DATA
);

  logic [5:0]                op;
  logic [5:0]                funct;
  logic [4:0]                shamt;
  logic [15:0]               imm;
  logic [REG_ADDR_WIDTH-1:0] rs, rt, rd;

  assign op    = INSTR[OP_LSB +: 6];
  assign rs    = REG_ADDR_WIDTH'(INSTR[RS_LSB +: 5]);
  assign rt    = REG_ADDR_WIDTH'(INSTR[RT_LSB +: 5]);
  assign rd    = REG_ADDR_WIDTH'(INSTR[RD_LSB +: 5]);
  assign shamt = INSTR[SHAMT_LSB +: 5];
  assign funct = INSTR[FUNCT_LSB +: 6];
  assign imm   = INSTR[IMM_LSB +: 16];

  logic [DATA_WIDTH-1:0] rf_rs_data, rf_rt_data;
  logic [DATA_WIDTH-1:0] rs_data, rt_data;

  register_file_32x32 #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_rf (
    .clk      (CLK),
    .rst      (RST),
    .rd0_addr (rs),
    .rd0_data (rf_rs_data),
    .rd1_addr (rt),
    .rd1_data (rf_rt_data),
    .we       (WB_EN),
    .waddr    (WB_ADDR),
    .wdata    (WB_DATA)
  );

`ifdef OPERAND_BYPASS_EN
  // Write-first: a write-back landing on this edge is seen by the instruction accepted on it.
  assign rs_data = (WB_EN && (WB_ADDR == rs) && (rs != '0)) ? WB_DATA : rf_rs_data;
  assign rt_data = (WB_EN && (WB_ADDR == rt) && (rt != '0)) ? WB_DATA : rf_rt_data;
`else
  // Read-first: the pre-write value is captured; the write still lands for later instructions.
  assign rs_data = rf_rs_data;
  assign rt_data = rf_rt_data;
`endif

  // Decode.
  logic [DATA_WIDTH-1:0]     dec_op1, dec_op2;
  alu_oprn_e                 dec_oprn;
  logic [REG_ADDR_WIDTH-1:0] dec_dest;
  logic                      dec_ill;
  logic [DATA_WIDTH-1:0]     imm_sext, imm_zext;

  assign imm_sext = {{(DATA_WIDTH-16){imm[15]}}, imm};
  assign imm_zext = DATA_WIDTH'(imm);

  always_comb begin
    dec_op1  = rs_data;
    dec_op2  = imm_sext;
    dec_oprn = ALU_NOP;
    dec_dest = rt;
    dec_ill  = 1'b0;
    unique case (op)
      OPC_RTYPE: begin
        dec_op2  = rt_data;
        dec_dest = rd;
        unique case (funct)
          FN_ADD:  dec_oprn = ALU_ADD;
          FN_SUB:  dec_oprn = ALU_SUB;
          FN_MUL:  dec_oprn = ALU_MUL;
          FN_AND:  dec_oprn = ALU_AND;
          FN_OR:   dec_oprn = ALU_OR;
          FN_NOR:  dec_oprn = ALU_NOR;
          FN_SLT:  dec_oprn = ALU_SLT;
          FN_SRL: begin
            dec_oprn = ALU_SRL;
            dec_op1  = rt_data;
            dec_op2  = DATA_WIDTH'(shamt);
          end
          FN_SLL: begin
            dec_oprn = ALU_SLL;
            dec_op1  = rt_data;
            dec_op2  = DATA_WIDTH'(shamt);
          end
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_ADDI: dec_oprn = ALU_ADD;
      OPC_MULI: dec_oprn = ALU_MUL;
      OPC_SLTI: dec_oprn = ALU_SLT;
      OPC_ANDI: begin
        dec_oprn = ALU_AND;
        dec_op2  = imm_zext;
      end
      OPC_ORI: begin
        dec_oprn = ALU_OR;
        dec_op2  = imm_zext;
      end
      OPC_LUI: begin
        // ALU builds the upper immediate as imm << 16.
        dec_oprn = ALU_SLL;
        dec_op1  = imm_zext;
        dec_op2  = DATA_WIDTH'(16);
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_op1  = '0;
      dec_op2  = '0;
      dec_oprn = ALU_NOP;
      dec_dest = '0;
    end
  end

  // Output register and handshake.
  logic                      out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0]     op1_q, op1_d, op2_q, op2_d;
  logic [OPRN_WIDTH-1:0]     oprn_q, oprn_d;
  logic [REG_ADDR_WIDTH-1:0] dest_q, dest_d;
  logic                      illegal_q, illegal_d;
  logic                      accept;

  assign IN_READY = !out_vld_q || OUT_READY;
  assign accept   = IN_VALID && IN_READY;

  always_comb begin
    out_vld_d = out_vld_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    oprn_d    = oprn_q;
    dest_d    = dest_q;
    illegal_d = illegal_q;
    if (accept) begin
      out_vld_d = 1'b1;
      op1_d     = dec_op1;
      op2_d     = dec_op2;
      oprn_d    = OPRN_WIDTH'(dec_oprn);
      dest_d    = dec_dest;
      illegal_d = dec_ill;
    end else if (OUT_READY) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_vld_q <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      oprn_q    <= '0;
      dest_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      out_vld_q <= out_vld_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      oprn_q    <= oprn_d;
      dest_q    <= dest_d;
      illegal_q <= illegal_d;
    end
  end

  assign OUT_VALID = out_vld_q;
  assign OP1       = op1_q;
  assign OP2       = op2_q;
  assign OPRN      = oprn_q;
  assign DEST      = dest_q;
  assign ILLEGAL   = illegal_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Purpose : self-checking bench for alu_operand_stage (decode table, backpressure, bypass, reset, illegal).
// Latency : expects OUT_VALID one cycle after each accept.
// Backpressure: exercises OUT_READY low holds and release.
module tb_alu_operand_stage;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [5:0]  oprn;
    logic [4:0]  dest;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    exp_t        want;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] INSTR = '0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] OP1, OP2;
  logic [5:0]  OPRN;
  logic [4:0]  DEST;
  logic        ILLEGAL;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic        WB_EN = 1'b0;
  logic [4:0]  WB_ADDR = '0;
  logic [31:0] WB_DATA = '0;

  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];

  always #5 CLK = ~CLK;

  alu_operand_stage dut (
    .CLK       (CLK),
    .RST       (RST),
    .INSTR     (INSTR),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .OP1       (OP1),
    .OP2       (OP2),
    .OPRN      (OPRN),
    .DEST      (DEST),
    .ILLEGAL   (ILLEGAL),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .WB_EN     (WB_EN),
    .WB_ADDR   (WB_ADDR),
    .WB_DATA   (WB_DATA)
  );

  function automatic logic [31:0] r_enc(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_enc(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=0x%08h want=0x%08h", name, got, want);
    end
  endtask

  // Scoreboard: every transfer (OUT_VALID && OUT_READY) pops one expectation.
  always @(negedge CLK) begin
    if (!RST && OUT_VALID && OUT_READY) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output got op1=%08h op2=%08h oprn=%02h dest=%0d ill=%0b",
                 OP1, OP2, OPRN, DEST, ILLEGAL);
      end else begin
        exp_t w;
        exp_t g;
        w = exp_q.pop_front();
        g = '{OP1, OP2, OPRN, DEST, ILLEGAL};
        if (g !== w) begin
          bad++;
          $display("FAIL xfer got op1=%08h op2=%08h oprn=%02h dest=%0d ill=%0b want op1=%08h op2=%08h oprn=%02h dest=%0d ill=%0b",
                   g.op1, g.op2, g.oprn, g.dest, g.ill, w.op1, w.op2, w.oprn, w.dest, w.ill);
        end
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    WB_EN = 1'b1; WB_ADDR = a; WB_DATA = d;
    tick();
    WB_EN = 1'b0;
  endtask

  task automatic issue(input logic [31:0] instr, input exp_t want, output int waited);
    logic rdy;
    exp_q.push_back(want);
    INSTR = instr;
    IN_VALID = 1'b1;
    waited = 0;
    forever begin
      @(negedge CLK);
      rdy = IN_READY;
      tick();
      waited++;
      if (rdy) break;
      if (waited > 50) begin
        check("accept_timeout", 32'(waited), 32'd0);
        break;
      end
    end
    IN_VALID = 1'b0;
  endtask

  vec_t vecs[17];

  initial begin
    int w;
    exp_t ea, eb;
    logic [31:0] byp_op1;

    vecs[0]  = '{r_enc(1, 2, 3, 0, 6'h20),  '{32'd7,        32'd5,        6'h01, 5'd3,  1'b0}};
    vecs[1]  = '{r_enc(6, 1, 7, 0, 6'h22),  '{32'hFFFFFFF0, 32'd7,        6'h02, 5'd7,  1'b0}};
    vecs[2]  = '{r_enc(1, 2, 8, 0, 6'h2c),  '{32'd7,        32'd5,        6'h03, 5'd8,  1'b0}};
    vecs[3]  = '{r_enc(3, 6, 9, 0, 6'h24),  '{32'h1234,     32'hFFFFFFF0, 6'h06, 5'd9,  1'b0}};
    vecs[4]  = '{r_enc(0, 1, 10, 0, 6'h25), '{32'd0,        32'd7,        6'h07, 5'd10, 1'b0}};
    vecs[5]  = '{r_enc(2, 3, 11, 0, 6'h27), '{32'd5,        32'h1234,     6'h08, 5'd11, 1'b0}};
    vecs[6]  = '{r_enc(6, 2, 12, 0, 6'h2a), '{32'hFFFFFFF0, 32'd5,        6'h09, 5'd12, 1'b0}};
    vecs[7]  = '{r_enc(5, 3, 13, 4, 6'h02), '{32'h1234,     32'd4,        6'h04, 5'd13, 1'b0}};
    vecs[8]  = '{r_enc(0, 1, 14, 31, 6'h01),'{32'd7,        32'd31,       6'h05, 5'd14, 1'b0}};
    vecs[9]  = '{i_enc(6'h08, 1, 4, 16'hFFFF), '{32'd7,     32'hFFFFFFFF, 6'h01, 5'd4,  1'b0}};
    vecs[10] = '{i_enc(6'h0d, 1, 4, 16'hFFFF), '{32'd7,     32'h0000FFFF, 6'h07, 5'd4,  1'b0}};
    vecs[11] = '{i_enc(6'h1d, 2, 5, 16'h0003), '{32'd5,     32'd3,        6'h03, 5'd5,  1'b0}};
    vecs[12] = '{i_enc(6'h0a, 6, 15, 16'h8000),'{32'hFFFFFFF0, 32'hFFFF8000, 6'h09, 5'd15, 1'b0}};
    vecs[13] = '{i_enc(6'h0c, 3, 16, 16'h8001),'{32'h1234,  32'h8001,     6'h06, 5'd16, 1'b0}};
    vecs[14] = '{i_enc(6'h0f, 1, 17, 16'hABCD),'{32'hABCD,  32'd16,       6'h05, 5'd17, 1'b0}};
    vecs[15] = '{i_enc(6'h3f, 1, 2, 16'h1234), '{32'd0,     32'd0,        6'h00, 5'd0,  1'b1}};
    vecs[16] = '{r_enc(1, 2, 3, 0, 6'h3f),     '{32'd0,     32'd0,        6'h00, 5'd0,  1'b1}};

    // Reset state.
    #3;
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_oprn", 32'(OPRN), 32'd0);
    check("rst_op1", OP1, 32'd0);
    check("rst_in_ready", 32'(IN_READY), 32'd1);
    tick();
    RST = 1'b0;
    tick();

    // Register preload; the R0 write must be ignored.
    wb_write(1, 32'd7);
    wb_write(2, 32'd5);
    wb_write(3, 32'h1234);
    wb_write(6, 32'hFFFFFFF0);
    wb_write(5, 32'h55);
    wb_write(0, 32'hDEAD);

    // Decode table at full throughput.
    for (int i = 0; i < 17; i++) begin
      issue(vecs[i].instr, vecs[i].want, w);
      check($sformatf("throughput_%0d", i), 32'(w), 32'd1);
    end
    tick();
    tick();

    // Backpressure: hold for 3 cycles, then release.
    OUT_READY = 1'b0;
    ea = '{32'd7, 32'd5, 6'h02, 5'd20, 1'b0};
    eb = '{32'h1234, 32'd7, 6'h07, 5'd21, 1'b0};
    issue(r_enc(1, 2, 20, 0, 6'h22), ea, w);
    INSTR = r_enc(3, 1, 21, 0, 6'h25);
    IN_VALID = 1'b1;
    exp_q.push_back(eb);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("bp_in_ready", 32'(IN_READY), 32'd0);
      check("bp_valid", 32'(OUT_VALID), 32'd1);
      check("bp_hold_op1", OP1, ea.op1);
      check("bp_hold_oprn", 32'(OPRN), 32'(ea.oprn));
      check("bp_hold_dest", 32'(DEST), 32'(ea.dest));
      tick();
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    check("bp_release_ready", 32'(IN_READY), 32'd1);
    tick();
    IN_VALID = 1'b0;
    @(negedge CLK);
    check("bp_next_valid", 32'(OUT_VALID), 32'd1);
    tick();
    @(negedge CLK);
    check("valid_fall", 32'(OUT_VALID), 32'd0);
    tick();

    // Same-cycle write-back to a source register.
`ifdef OPERAND_BYPASS_EN
    byp_op1 = 32'h99;
`else
    byp_op1 = 32'd7;
`endif
    WB_EN = 1'b1; WB_ADDR = 5'd1; WB_DATA = 32'h99;
    issue(r_enc(1, 2, 3, 0, 6'h20), '{byp_op1, 32'd5, 6'h01, 5'd3, 1'b0}, w);
    WB_EN = 1'b0;
    issue(r_enc(1, 1, 2, 0, 6'h20), '{32'h99, 32'h99, 6'h01, 5'd2, 1'b0}, w);
    // Write to R0 in the accept cycle: never forwarded, never stored.
    WB_EN = 1'b1; WB_ADDR = 5'd0; WB_DATA = 32'hBEEF;
    issue(r_enc(0, 0, 4, 0, 6'h20), '{32'd0, 32'd0, 6'h01, 5'd4, 1'b0}, w);
    WB_EN = 1'b0;
    issue(r_enc(0, 1, 4, 0, 6'h25), '{32'd0, 32'h99, 6'h07, 5'd4, 1'b0}, w);
    tick();
    tick();

    // Reset mid-transfer discards the held instruction and clears the register file.
    OUT_READY = 1'b0;
    issue(r_enc(5, 2, 9, 0, 6'h20), '{32'h55, 32'd5, 6'h01, 5'd9, 1'b0}, w);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("mid_rst_oprn", 32'(OPRN), 32'd0);
    check("mid_rst_in_ready", 32'(IN_READY), 32'd1);
    exp_q.delete();
    tick();
    RST = 1'b0;
    OUT_READY = 1'b1;
    tick();
    issue(r_enc(5, 1, 2, 0, 6'h20), '{32'd0, 32'd0, 6'h01, 5'd2, 1'b0}, w);

    // Drain the scoreboard.
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch/decode stage directly upstream of the 32-bit combinational ALU.
- Accepts a 32-bit MIPS-style instruction with a valid/ready handshake and decodes R/I-type fields.
- Reads two operands from an internal 32x32 register file and drives registered OP1/OP2/OPRN/DEST to the ALU.
- Accepts ALU results back through a write-back port.

Parameters:
- DATA_WIDTH, 32, operand/register width.
- REG_ADDR_WIDTH, 5, register index width (2^5 = 32 entries).
- OPRN_WIDTH, 6, ALU operation code width.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- INSTR  input  32  instruction word.
- IN_VALID  input  1  INSTR is valid.
- IN_READY  output  1  stage can accept INSTR this cycle.
- OP1  output  DATA_WIDTH  ALU operand 1.
- OP2  output  DATA_WIDTH  ALU operand 2.
- OPRN  output  OPRN_WIDTH  ALU operation code.
- DEST  output  REG_ADDR_WIDTH  destination register for the result.
- ILLEGAL  output  1  decoded instruction is unsupported.
- OUT_VALID  output  1  OP1/OP2/OPRN/DEST/ILLEGAL are valid.
- OUT_READY  input  1  downstream consumes the outputs.
- WB_EN  input  1  write-back enable.
- WB_ADDR  input  REG_ADDR_WIDTH  write-back register index.
- WB_DATA  input  DATA_WIDTH  write-back data (the ALU OUT).

Behaviour:
- Reset (async, active-high):
  - OUT_VALID=0; OP1, OP2, OPRN, DEST, ILLEGAL = 0; all 32 registers = 0.
  - A reset mid-transfer discards the held instruction.
- Handshake:
  - IN_READY = !OUT_VALID || OUT_READY (combinational).
  - Accept occurs on IN_VALID && IN_READY; outputs register at that edge, so OUT_VALID rises 1 cycle after accept.
  - Outputs hold stable while OUT_VALID && !OUT_READY.
  - OUT_VALID falls after a consume edge with no new accept.
  - Back-to-back accept gives full throughput.
- Decode fields: op=INSTR[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=[15:0].
- R-type (op=0x00), DEST=rd:
  - add 0x20 -> OPRN 0x01, OP1=R[rs], OP2=R[rt].
  - sub 0x22 -> 0x02, same operands.
  - mul 0x2c -> 0x03, same operands.
  - and 0x24 -> 0x06, same operands.
  - or 0x25 -> 0x07, same operands.
  - nor 0x27 -> 0x08, same operands.
  - slt 0x2a -> 0x09, same operands.
  - srl 0x02 -> 0x04, OP1=R[rt], OP2=zero-extended shamt.
  - sll 0x01 -> 0x05, OP1=R[rt], OP2=zero-extended shamt.
- I-type, DEST=rt, OP1=R[rs], OP2 sign-extended imm unless noted:
  - addi 0x08 -> 0x01.
  - muli 0x1d -> 0x03.
  - slti 0x0a -> 0x09.
  - andi 0x0c -> 0x06, OP2 zero-extended imm.
  - ori 0x0d -> 0x07, OP2 zero-extended imm.
  - lui 0x0f -> 0x05, OP1=zero-extended imm, OP2=16.
- Any other op/funct: ILLEGAL=1, OPRN=0, OP1=OP2=0, DEST=0. The transfer still completes through the handshake.
- Register file:
  - R[0] always reads 0; writes to index 0 are ignored.
  - WB_EN writes R[WB_ADDR]=WB_DATA at the edge, independent of the handshake.
  - Reads are combinational from the current array at the accept edge.

Optional Feature:
- Macro: OPERAND_BYPASS_EN.
- Defined: if WB_EN is high in the accept cycle and WB_ADDR equals a nonzero source index, WB_DATA is forwarded into OP1/OP2 (write-first).
- Undefined: the pre-write register value is captured. The write still lands, and the next instruction sees the new value.

Decomposition:
- Shared package/include holds ALU opcode constants 0x01–0x09, opcode/funct constants, field bit positions, and DATA_WIDTH/REG_ADDR_WIDTH defaults.
- One sub-module: register_file_32x32, with 2 async read ports, 1 sync write port, async reset and R0 hardwired to zero.
- Decode and handshake logic lives in the top.

Test Plan:
- Reset check: assert RST mid-stream -> OUT_VALID=0, OPRN=0, IN_READY=1; R[5] reads 0 afterward.
- R-type add: write R[1]=7 and R[2]=5, then issue add rd=3 (INSTR 0x00221820) -> next cycle OUT_VALID=1, OP1=7, OP2=5, OPRN=0x01, DEST=3.
- addi sign extension: addi rt=4, rs=1, imm=0xFFFF -> OP1=7, OP2=0xFFFFFFFF, OPRN=0x01, DEST=4. The same imm via ori -> OP2=0x0000FFFF, OPRN=0x07.
- Backpressure: hold OUT_READY=0 for 3 cycles with IN_VALID=1 -> IN_READY=0 and outputs stable. Release -> next instruction presents 1 cycle later with no loss or duplication.
- Bypass: WB_EN=1, WB_ADDR=1, WB_DATA=0x99 in the same cycle as accepting add rs=1 -> OP1=0x99 with OPERAND_BYPASS_EN defined, OP1=7 without it. WB_ADDR=0 writes are ignored, so R[0] stays 0.
- Illegal: op=0x3f -> ILLEGAL=1, OPRN=0, and the handshake completes normally.
